// File: rtl/clint_timer_pkg.sv
// Shared constants and helpers for the core-local timer (clint_timer).
package clint_timer_pkg;

   localparam int DATA_BUS_SIZE = 64;
   typedef logic [DATA_BUS_SIZE-1:0] data_bus_t;

   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

   localparam data_bus_t CLINT_MTIMECMP_RST = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } clint_state_e;

   function automatic data_bus_t expand_mask(input logic [7:0] mask);
      data_bus_t m;
      for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{mask[b]}};
      return m;
   endfunction

   function automatic data_bus_t merge_bytes(input data_bus_t old_v, input data_bus_t new_v,
                                             input logic [7:0] mask);
      data_bus_t m;
      m = expand_mask(mask);
      return (old_v & ~m) | (new_v & m);
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the core clock by TICK_DIV into a one-cycle mtime tick pulse.
module clint_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   generate
      if (TICK_DIV == 1) begin : g_div1
         logic w_unused;
         assign w_unused = clk | rst;
         assign tick     = 1'b1;
      end else begin : g_divn
         logic [CW-1:0] r_cnt;
         logic          w_wrap;

         assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
         assign tick   = w_wrap;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)         r_cnt <= '0;
            else if (w_wrap) r_cnt <= '0;
            else             r_cnt <= r_cnt + 1'b1;
         end
      end
   endgenerate

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp with a level timer interrupt.
// Optional msip register and clint_msip port are enabled by defining CLINT_MSIP_EN.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int          TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        clint_mtip
`ifdef CLINT_MSIP_EN
   ,
   output logic        clint_msip
`endif
);

   clint_state_e r_state;
   logic         r_req_ready;
   logic         r_resp_valid;
   data_bus_t    r_resp_rdata;
   logic         r_resp_err;
   logic         r_mtip;
   data_bus_t    r_mtime;
   data_bus_t    r_mtimecmp;

   logic         w_tick;
   logic         w_acc;
   data_bus_t    w_off;
   logic         w_in_win;
   logic         w_sel_cmp;
   logic         w_sel_time;
   logic         w_hit;
   logic         w_wr;
   data_bus_t    w_rdata;
   data_bus_t    w_mtime_nxt;
   data_bus_t    w_mtimecmp_nxt;

   clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Addresses below BASE_ADDR wrap to huge offsets and fall outside the window.
   assign w_off      = req_addr - BASE_ADDR;
   assign w_in_win   = (w_off[63:16] == '0) && (req_addr[2:0] == 3'b000);
   assign w_sel_cmp  = w_in_win && (w_off[15:0] == CLINT_MTIMECMP_OFF);
   assign w_sel_time = w_in_win && (w_off[15:0] == CLINT_MTIME_OFF);

`ifdef CLINT_MSIP_EN
   logic w_sel_msip;
   logic r_msip;
   assign w_sel_msip = w_in_win && (w_off[15:0] == CLINT_MSIP_OFF);
   assign w_hit      = w_sel_cmp | w_sel_time | w_sel_msip;
`else
   assign w_hit      = w_sel_cmp | w_sel_time;
`endif

   assign w_acc = req_valid & r_req_ready;
   assign w_wr  = w_acc & req_wen & w_hit;

   // A software write to mtime overrides (drops) a coincident tick.
   always_comb begin
      w_mtime_nxt = r_mtime;
      if (w_wr && w_sel_time) w_mtime_nxt = merge_bytes(r_mtime, req_wdata, req_wmask);
      else if (w_tick)        w_mtime_nxt = r_mtime + 64'd1;
   end

   always_comb begin
      w_mtimecmp_nxt = r_mtimecmp;
      if (w_wr && w_sel_cmp) w_mtimecmp_nxt = merge_bytes(r_mtimecmp, req_wdata, req_wmask);
   end

   always_comb begin
      w_rdata = '0;
      if (!req_wen) begin
         if (w_sel_cmp)       w_rdata = r_mtimecmp;
         else if (w_sel_time) w_rdata = r_mtime;
`ifdef CLINT_MSIP_EN
         else if (w_sel_msip) w_rdata = {63'b0, r_msip};
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtime    <= '0;
         r_mtimecmp <= CLINT_MTIMECMP_RST;
         r_mtip     <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_mtimecmp_nxt;
         r_mtip     <= (w_mtime_nxt >= w_mtimecmp_nxt);
      end
   end

`ifdef CLINT_MSIP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   r_msip <= 1'b0;
      else if (w_wr && w_sel_msip && req_wmask[0]) r_msip <= req_wdata[0];
   end
   assign clint_msip = r_msip;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_acc) begin
               r_state      <= ST_RESP;
               r_req_ready  <= 1'b0;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_rdata;
               r_resp_err   <= ~w_hit;
            end
            ST_RESP: if (resp_ready) begin
               r_state      <= ST_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
               r_resp_rdata <= '0;
               r_resp_err   <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign clint_mtip = r_mtip;

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer (TICK_DIV = 1).
module tb_clint_timer;

   localparam logic [63:0] B    = 64'h0000_0000_0200_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk, rst;
   logic        req_valid, req_ready, req_wen;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic        clint_mtip;
`ifdef CLINT_MSIP_EN
   logic        clint_msip;
`endif

   int errors = 0;
   int checks = 0;

   clint_timer #(.BASE_ADDR(B), .TICK_DIV(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wmask  (req_wmask),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .clint_mtip (clint_mtip)
`ifdef CLINT_MSIP_EN
      ,
      .clint_msip (clint_msip)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response is consumed.
   task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] wm, output logic [63:0] rd, output logic er);
      int n;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("resp_valid", 64'(resp_valid), 64'd1);
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready",  64'(req_ready),  64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", resp_rdata,      64'd0);
      check("rst_resp_err",   64'(resp_err),   64'd0);
      check("rst_mtip",       64'(clint_mtip), 64'd0);
      rst = 1'b0;

      // 10 ticks after release, read returns the pre-tick value at the accept edge
      repeat (10) @(negedge clk);
      do_req(1'b0, B + 64'hBFF8, '0, 8'h00, rd, er);
      check("mtime_after_10", rd, 64'd10);
      check("mtime_rd_err", 64'(er), 64'd0);
      check("mtip_idle", 64'(clint_mtip), 64'd0);

      // mtimecmp = 20: written when mtime goes 12->13
      do_req(1'b1, B + 64'h4000, 64'd20, 8'hFF, rd, er);
      check("cmp_wr_err", 64'(er), 64'd0);
      check("mtip_at_14", 64'(clint_mtip), 64'd0);
      repeat (5) @(negedge clk);
      check("mtip_at_19", 64'(clint_mtip), 64'd0);
      @(negedge clk);
      check("mtip_at_20", 64'(clint_mtip), 64'd1);
      do_req(1'b1, B + 64'h4000, ONES, 8'hFF, rd, er);
      check("mtip_cmp_max", 64'(clint_mtip), 64'd0);

      // Byte-masked mtime write coinciding with a tick: tick dropped
      do_req(1'b1, B + 64'hBFF8, 64'h0123_4567_0000_1234, 8'hFF, rd, er);
      do_req(1'b1, B + 64'hBFF8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h03, rd, er);
      check("mtime_part_wr_rdata", rd, 64'd0);
      do_req(1'b0, B + 64'hBFF8, '0, 8'h00, rd, er);
      check("mtime_merge", rd, 64'h0123_4567_0000_DDDE);

      // Partial write to mtimecmp
      do_req(1'b1, B + 64'h4000, 64'h0000_0000_0000_0005, 8'h0F, rd, er);
      do_req(1'b0, B + 64'h4000, '0, 8'h00, rd, er);
      check("cmp_merge", rd, 64'hFFFF_FFFF_0000_0005);
      do_req(1'b1, B + 64'h4000, 64'd5, 8'hFF, rd, er);
      check("mtip_cmp5", 64'(clint_mtip), 64'd1);

      // Wrap from all-ones
      do_req(1'b1, B + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
      check("mtip_pre_wrap", 64'(clint_mtip), 64'd1);
      @(negedge clk);
      check("mtip_wrap", 64'(clint_mtip), 64'd0);
      repeat (4) @(negedge clk);
      check("mtip_at_4", 64'(clint_mtip), 64'd0);
      @(negedge clk);
      check("mtip_at_5", 64'(clint_mtip), 64'd1);
      do_req(1'b0, B + 64'hBFF8, '0, 8'h00, rd, er);
      check("mtime_after_wrap", rd, 64'd5);

      // Error accesses
      do_req(1'b0, B + 64'h0008, '0, 8'h00, rd, er);
      check("err_0008", 64'(er), 64'd1);
      check("err_0008_rd", rd, 64'd0);
      do_req(1'b0, B + 64'h4004, '0, 8'h00, rd, er);
      check("err_4004", 64'(er), 64'd1);
      check("err_4004_rd", rd, 64'd0);
      do_req(1'b1, B + 64'h4004, 64'h99, 8'hFF, rd, er);
      check("err_wr_4004", 64'(er), 64'd1);
      do_req(1'b1, B - 64'h8, 64'h99, 8'hFF, rd, er);
      check("err_below_base", 64'(er), 64'd1);
      do_req(1'b1, B + 64'h1_4000, 64'h99, 8'hFF, rd, er);
      check("err_above_win", 64'(er), 64'd1);
`ifndef CLINT_MSIP_EN
      do_req(1'b0, B, '0, 8'h00, rd, er);
      check("err_msip_off", 64'(er), 64'd1);
`endif

      // Back-pressure: response held stable, no new accept
      check("stall_req_ready0", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = B + 64'h4000;
      @(posedge clk);
      @(negedge clk);
      req_wen = 1'b1; req_wdata = 64'd77; req_wmask = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", 64'(resp_valid), 64'd1);
         check("stall_rdata", resp_rdata, 64'd5);
         check("stall_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check("stall_done_valid", 64'(resp_valid), 64'd0);
      do_req(1'b0, B + 64'h4000, '0, 8'h00, rd, er);
      check("cmp_unchanged", rd, 64'd5);

      // Asynchronous reset while a response is pending
      req_valid = 1'b1; req_wen = 1'b0; req_addr = B + 64'hBFF8;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_valid", 64'(resp_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(resp_valid), 64'd0);
      check("async_rst_ready", 64'(req_ready), 64'd1);
      check("async_rst_mtip", 64'(clint_mtip), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b0, B + 64'hBFF8, '0, 8'h00, rd, er);
      check("mtime_post_rst", rd, 64'd0);
      do_req(1'b0, B + 64'h4000, '0, 8'h00, rd, er);
      check("cmp_post_rst", rd, ONES);

`ifdef CLINT_MSIP_EN
      check("msip_rst", 64'(clint_msip), 64'd0);
      do_req(1'b1, B, 64'h1, 8'h01, rd, er);
      check("msip_wr_err", 64'(er), 64'd0);
      check("msip_set", 64'(clint_msip), 64'd1);
      do_req(1'b1, B, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
      do_req(1'b0, B, '0, 8'h00, rd, er);
      check("msip_rd_clr", rd, 64'd0);
      do_req(1'b1, B, ONES, 8'hFF, rd, er);
      do_req(1'b0, B, '0, 8'h00, rd, er);
      check("msip_rd_set", rd, 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
